inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: pc_i  input  64  fetch address from PC generator.
REQ-004 SHALL have: flush_i  input  1  redirect from ID/EX; discard in-flight fetch.
REQ-005 SHALL have: stall_i  input  1  IF/ID pipeline stall (stall_ctrl[1]).
REQ-006 SHALL have: mem_req_valid_o  output  1  instruction-memory read request valid.
REQ-007 SHALL have: mem_req_addr_o  output  64  request address.
REQ-008 SHALL have: mem_req_ready_i  input  1  memory accepts request.
REQ-009 SHALL have: mem_resp_valid_i  input  1  read data valid; memory never back-pressures responses.
REQ-010 SHALL have: mem_resp_data_i  input  32  instruction word.
REQ-011 SHALL have: inst_valid_o  output  1  instruction presented to ID.
REQ-012 SHALL have: inst_o  output  32  instruction word to ID.
REQ-013 SHALL have: inst_pc_o  output  64  address of inst_o.
REQ-014 SHALL have: inst_misalign_o  output  1  inst_pc_o[1:0] != 0.
REQ-015 SHALL have: fetch_stall_req_o  output  1  request to hold PC (drives stall_ctrl[0] source).

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, DRAIN; at most one outstanding memory request.
REQ-017 IDLE SHALL latch pc_i into addr register and go to REQ next cycle.
REQ-018 REQ SHALL assert mem_req_valid_o with mem_req_addr_o = latched addr; valid/addr SHALL stay stable until mem_req_valid_o & mem_req_ready_i, then go to WAIT.
REQ-019 WAIT, on mem_resp_valid_i: SHALL register inst_o = data, inst_pc_o = addr, inst_valid_o = 1 the following cycle (1-cycle response-to-ID latency); if stall_i = 0 go to REQ latching pc_i, else go to HOLD.
REQ-020 HOLD SHALL keep inst_o/inst_pc_o/inst_valid_o constant while stall_i = 1; on stall_i = 0 SHALL go to REQ latching pc_i.
REQ-021 inst_valid_o SHALL deassert the cycle after ID consumes it (stall_i = 0) unless a new response is registered in the same cycle.
REQ-022 Misaligned addr (addr[1:0] != 0) SHALL issue no memory request; SHALL present inst_o = 32'h00000013, inst_misalign_o = 1, inst_valid_o = 1 next cycle, then follow REQ-019/020 rules.
REQ-023 fetch_stall_req_o SHALL be 1 in REQ, WAIT, DRAIN; 0 in IDLE and HOLD.
REQ-024 flush_i in REQ before handshake: request SHALL still complete; then DRAIN.
REQ-025 flush_i in WAIT without mem_resp_valid_i: go to DRAIN; with mem_resp_valid_i same cycle: response SHALL be discarded, go to REQ latching pc_i.
REQ-026 DRAIN SHALL discard the next response, then go to REQ latching pc_i.
REQ-027 flush_i in any state SHALL clear inst_valid_o next cycle; flush_i in HOLD SHALL go to REQ latching pc_i.
REQ-028 flush_i has priority over stall_i in the same cycle.

Reset
REQ-029 rst SHALL force state IDLE, mem_req_valid_o = 0, mem_req_addr_o = 0, inst_valid_o = 0, inst_o = 0, inst_pc_o = 0, inst_misalign_o = 0, fetch_stall_req_o = 0.
REQ-030 rst during WAIT SHALL abandon the outstanding request; memory is reset by the same rst.

Structure
REQ-031 Shared defines SHALL hold PC width (64), instruction width (32), reset start address, NOP encoding, FSM state encodings.
REQ-032 Single module; one-entry instruction holding register inline, no sub-module.

Verification
REQ-033 Reset then pc_i = 0x80000000, ready = 1, response 2 cycles later with 0x00000297 -> inst_valid_o = 1, inst_o = 0x00000297, inst_pc_o = 0x80000000.
REQ-034 mem_req_ready_i = 0 for 3 cycles -> mem_req_valid_o = 1, addr constant, fetch_stall_req_o = 1 throughout.
REQ-035 stall_i = 1 for 4 cycles after response -> inst_o/inst_pc_o unchanged, no new request, fetch_stall_req_o = 0.
REQ-036 flush_i in WAIT, pc_i = 0x80000100 -> old response discarded, inst_valid_o stays 0, next request addr = 0x80000100.
REQ-037 flush_i coincident with mem_resp_valid_i -> no inst_valid_o, next-cycle request to new pc_i.
REQ-038 pc_i = 0x80000002 -> no mem_req_valid_o, inst_o = 0x00000013, inst_misalign_o = 1.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared widths, constants and FSM encodings for the instruction fetch stage.
package inst_fetch_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned INST_W = 32;

    localparam logic [PC_W-1:0]   RESET_ADDR = 64'h0000_0000_0000_0000;
    localparam logic [INST_W-1:0] NOP_INST   = 32'h0000_0013;  // addi x0, x0, 0

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding memory read, one-entry holding
// register toward ID, flush/stall handling and misaligned-PC NOP injection.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              flush_i,
    input  logic              stall_i,
    output logic              mem_req_valid_o,
    output logic [PC_W-1:0]   mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_resp_valid_i,
    input  logic [INST_W-1:0] mem_resp_data_i,
    output logic              inst_valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   inst_pc_o,
    output logic              inst_misalign_o,
    output logic              fetch_stall_req_o
);

    fetch_state_e      r_state;
    fetch_state_e      w_next_state;
    logic [PC_W-1:0]   r_addr;
    logic [INST_W-1:0] r_inst;
    logic [PC_W-1:0]   r_inst_pc;
    logic              r_inst_valid;
    logic              r_flush_pend;

    logic w_misaligned;
    logic w_handshake;
    logic w_latch_pc;
    logic w_load_resp;
    logic w_load_nop;
    logic w_flush_pend;

    assign w_misaligned = (r_addr[1:0] != 2'b00);
    assign w_handshake  = mem_req_valid_o && mem_req_ready_i;

    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_latch_pc   = 1'b0;
        w_load_resp  = 1'b0;
        w_load_nop   = 1'b0;
        w_flush_pend = r_flush_pend;
        case (r_state)
            S_IDLE: begin
                w_latch_pc   = 1'b1;
                w_next_state = S_REQ;
            end
            S_REQ: begin
                if (w_misaligned) begin
                    // No memory access: the NOP acts as an immediate response.
                    if (flush_i) begin
                        w_latch_pc = 1'b1;
                    end else begin
                        w_load_nop = 1'b1;
                        if (stall_i) w_next_state = S_HOLD;
                        else         w_latch_pc   = 1'b1;
                    end
                end else if (w_handshake) begin
                    w_flush_pend = 1'b0;
                    w_next_state = (flush_i || r_flush_pend) ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    // The request must still complete, so remember the flush.
                    w_flush_pend = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid_i) begin
                    if (flush_i) begin
                        w_latch_pc   = 1'b1;
                        w_next_state = S_REQ;
                    end else begin
                        w_load_resp = 1'b1;
                        if (stall_i) begin
                            w_next_state = S_HOLD;
                        end else begin
                            w_latch_pc   = 1'b1;
                            w_next_state = S_REQ;
                        end
                    end
                end else if (flush_i) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (flush_i || !stall_i) begin
                    w_latch_pc   = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            S_DRAIN: begin
                if (mem_resp_valid_i) begin
                    w_latch_pc   = 1'b1;
                    w_next_state = S_REQ;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_addr       <= RESET_ADDR;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_flush_pend <= w_flush_pend;
            if (w_latch_pc) r_addr <= pc_i;
            if (w_load_resp) begin
                r_inst    <= mem_resp_data_i;
                r_inst_pc <= r_addr;
            end else if (w_load_nop) begin
                r_inst    <= NOP_INST;
                r_inst_pc <= r_addr;
            end
            // A new instruction wins; otherwise flush or consumption by ID clears it.
            if (w_load_resp || w_load_nop)  r_inst_valid <= 1'b1;
            else if (flush_i || !stall_i)   r_inst_valid <= 1'b0;
        end
    end

    assign mem_req_valid_o   = (r_state == S_REQ) && !w_misaligned;
    assign mem_req_addr_o    = r_addr;
    assign inst_valid_o      = r_inst_valid;
    assign inst_o            = r_inst;
    assign inst_pc_o         = r_inst_pc;
    assign inst_misalign_o   = (r_inst_pc[1:0] != 2'b00);
    assign fetch_stall_req_o = (r_state == S_REQ) || (r_state == S_WAIT) ||
                               (r_state == S_DRAIN);

endmodule
